mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, data width of each requester channel.
REQ-002 SHALL have parameter HOLD, default 4, maximum number of consecutive data beats per grant (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-requester request; bit i belongs to requester i.
REQ-006 SHALL have ports din0, din1, din2, din3  input  DW each  requester data.
REQ-007 SHALL have port gnt  output  4  registered one-hot grant, or all zero.
REQ-008 SHALL have port sel  output  2  registered index of the current or last granted requester.
REQ-009 SHALL have port dout  output  DW  registered output of the shared mux.
REQ-010 SHALL have port dout_vld  output  1  registered qualifier for dout.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 SHALL keep a 2-bit round-robin pointer, last, holding the most recently granted index.
REQ-013 In IDLE with req != 0, SHALL select the first set req bit searching last+1, last+2, last+3, last (mod 4).
- Next edge: gnt = onehot(winner), sel = winner, last = winner, state = GRANT, beat counter = 0.
REQ-014 In IDLE with req == 0, SHALL hold state, keep gnt = 0 and dout_vld = 0, and leave sel, last and dout unchanged.
REQ-015 In GRANT, SHALL qualify each cycle as a beat when req[sel] = 1.
- Next edge on a beat: dout = din[sel] (din0..din3 for sel 0..3), dout_vld = 1, counter += 1.
REQ-016 In GRANT, SHALL release the grant when a beat occurs with counter = HOLD-1.
- Next edge: that beat's dout/dout_vld as in REQ-015, gnt = 0, state = IDLE, counter = 0.
REQ-017 In GRANT, SHALL release the grant when req[sel] = 0.
- Next edge: gnt = 0, dout_vld = 0, dout unchanged, state = IDLE, counter = 0.
REQ-018 SHALL insert exactly one IDLE cycle between consecutive grants and SHALL not grant in the cycle of release.
REQ-019 SHALL ignore changes to req bits other than req[sel] while in GRANT.
REQ-020 SHALL ignore din values except din[sel] during a beat.
REQ-021 SHALL drive dout_vld = 0 on every cycle not immediately preceded by a beat.
REQ-022 SHALL keep the beat counter 4 bits wide and never let it exceed HOLD-1.
REQ-023 SHALL guarantee gnt is one-hot in GRANT and zero in IDLE, and never two bits set.
REQ-024 With all four req held high, SHALL grant in order 0,1,2,3,0,... with HOLD beats each.

Reset
REQ-025 On rst = 1, SHALL immediately (asynchronously) set:
- state = IDLE, gnt = 0, sel = 0, dout = 0, dout_vld = 0, counter = 0
- last = 3, so requester 0 has first priority.
REQ-026 If rst asserts mid-grant, SHALL abort the grant with no further beat.
- After deassertion, arbitration restarts per REQ-013 from last = 3.
REQ-027 SHALL register the first grant after rst deasserts no earlier than the first rising edge with rst low.

Verification
REQ-028 Reset: assert rst with req = 4'b1111 -> gnt = 0, dout_vld = 0, dout = 0.
- Release rst -> first edge gives gnt = 4'b0001, sel = 0.
REQ-029 Single requester: req = 4'b0100 held, din2 = 8'hA5, HOLD = 4.
- gnt = 4'b0100 one edge after the request.
- dout = A5 with dout_vld = 1 for 4 cycles.
- One cycle with gnt = 0, dout_vld = 0; then regrant 4'b0100.
REQ-030 Round robin: req = 4'b1111, din_i = i.
- Grant sequence 0,1,2,3,0.
- Each grant yields 4 valid beats of value i, separated by one idle cycle.
REQ-031 Early drop: requester 1 granted, req[1] drops after 2 beats.
- Exactly 2 valid beats, then gnt = 0, dout_vld = 0 on the next edge.
- Next winner is the first requester after 1.
REQ-032 Async reset mid-burst: rst pulsed between clock edges during beat 2.
- gnt, dout_vld, dout clear without a clock edge.
- No beat 3.
- After release, grant restarts at requester 0.
REQ-033 Ignored request: during a grant to 3, toggle req[0] and din0.
- No effect on dout.
- After release, requester 0 wins next.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin 4:1 arbiter feeding a registered shared data mux; grant lands one edge after request, data one edge after each beat.
// No backpressure: a granted requester ends its burst by dropping req, or is cut off after HOLD beats.
module mux_rr_arbiter #(
    parameter int DW   = 8,
    parameter int HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_vld
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [3:0] CNT_MAX = 4'(HOLD - 1);

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          vld_q, vld_d;

    logic          win_vld;
    logic [1:0]    win_idx;
    logic [1:0]    idx;
    logic [DW-1:0] din_sel;

    // Scan from lowest priority (last) up to highest (last+1) so the highest hit wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last_q;
        idx     = last_q;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + k[1:0];
            if (req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    din_sel = din0;
            2'd1:    din_sel = din1;
            2'd2:    din_sel = din2;
            default: din_sel = din3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (win_vld) begin
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (req[sel_q]) begin
                    dout_d = din_sel;
                    vld_d  = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        gnt_d   = 4'b0000;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    gnt_d   = 4'b0000;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            cnt_q   <= 4'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign dout     = dout_q;
    assign dout_vld = vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, round robin, single requester, early drop, ignored requests, async reset.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] din0, din1, din2, din3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       dout_vld;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] d0, d1, d2, d3;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [7:0] dout;
        logic       vld;
    } vec_t;

    vec_t vecs[$];

    mux_rr_arbiter #(.DW(8), .HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din0     (din0),
        .din1     (din1),
        .din2     (din2),
        .din3     (din3),
        .gnt      (gnt),
        .sel      (sel),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3, input logic [3:0] g,
                       input logic [1:0] s, input logic [7:0] d, input logic v);
        vec_t e;
        e.req = r; e.d0 = d0; e.d1 = d1; e.d2 = d2; e.d3 = d3;
        e.gnt = g; e.sel = s; e.dout = d; e.vld = v;
        vecs.push_back(e);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'hF;
        din0 = 8'hC0; din1 = 8'hC1; din2 = 8'hC2; din3 = 8'hC3;

        // Round robin with all requests high: 4 beats each, one idle edge between grants.
        for (int r = 0; r < 4; r++) begin
            add(4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'(1 << r), 2'(r),
                (r == 0) ? 8'h00 : 8'hC0 + 8'(r - 1), 1'b0);
            for (int b = 0; b < 3; b++)
                add(4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'(1 << r), 2'(r), 8'hC0 + 8'(r), 1'b1);
            add(4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'b0000, 2'(r), 8'hC0 + 8'(r), 1'b1);
        end
        add(4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'b0001, 2'd0, 8'hC3, 1'b0);
        // Requester 0 drops with no beat; then requester 2 alone, full burst and regrant.
        add(4'h4, 8'hC0, 8'hC1, 8'hA5, 8'hC3, 4'b0000, 2'd0, 8'hC3, 1'b0);
        add(4'h4, 8'hC0, 8'hC1, 8'hA5, 8'hC3, 4'b0100, 2'd2, 8'hC3, 1'b0);
        add(4'h4, 8'hC0, 8'hC1, 8'hA5, 8'hC3, 4'b0100, 2'd2, 8'hA5, 1'b1);
        add(4'h4, 8'hC0, 8'hC1, 8'hA5, 8'hC3, 4'b0100, 2'd2, 8'hA5, 1'b1);
        add(4'h4, 8'hC0, 8'hC1, 8'hA5, 8'hC3, 4'b0100, 2'd2, 8'hA5, 1'b1);
        add(4'h4, 8'hC0, 8'hC1, 8'hA5, 8'hC3, 4'b0000, 2'd2, 8'hA5, 1'b1);
        add(4'h4, 8'hC0, 8'hC1, 8'hA5, 8'hC3, 4'b0100, 2'd2, 8'hA5, 1'b0);
        // Early drop: requester 1 gives two beats, then 3 wins over 0.
        add(4'h0, 8'hC0, 8'hC1, 8'hA5, 8'hC3, 4'b0000, 2'd2, 8'hA5, 1'b0);
        add(4'h2, 8'hC0, 8'h5A, 8'hA5, 8'hC3, 4'b0010, 2'd1, 8'hA5, 1'b0);
        add(4'h2, 8'hC0, 8'h5A, 8'hA5, 8'hC3, 4'b0010, 2'd1, 8'h5A, 1'b1);
        add(4'h2, 8'hC0, 8'h5A, 8'hA5, 8'hC3, 4'b0010, 2'd1, 8'h5A, 1'b1);
        add(4'h9, 8'hC0, 8'h5A, 8'hA5, 8'hC3, 4'b0000, 2'd1, 8'h5A, 1'b0);
        add(4'h9, 8'hC0, 8'h5A, 8'hA5, 8'h3C, 4'b1000, 2'd3, 8'h5A, 1'b0);
        // Requester 3 granted: req[0] and din0 toggling must not matter.
        add(4'h8, 8'hFF, 8'h5A, 8'hA5, 8'h3C, 4'b1000, 2'd3, 8'h3C, 1'b1);
        add(4'h9, 8'h11, 8'h5A, 8'hA5, 8'h3C, 4'b1000, 2'd3, 8'h3C, 1'b1);
        add(4'h8, 8'h22, 8'h5A, 8'hA5, 8'h3C, 4'b1000, 2'd3, 8'h3C, 1'b1);
        add(4'h9, 8'h33, 8'h5A, 8'hA5, 8'h3C, 4'b0000, 2'd3, 8'h3C, 1'b1);
        add(4'h9, 8'h77, 8'h5A, 8'hA5, 8'h3C, 4'b0001, 2'd0, 8'h3C, 1'b0);

        // Reset is asynchronous: outputs clear before any clock edge.
        #1;
        check("rst_async gnt", 32'(gnt), 32'h0);
        check("rst_async vld", 32'(dout_vld), 32'h0);
        step();
        step();
        check("rst gnt", 32'(gnt), 32'h0);
        check("rst vld", 32'(dout_vld), 32'h0);
        check("rst dout", 32'(dout), 32'h0);
        check("rst sel", 32'(sel), 32'h0);
        rst = 1'b0;
        #2;
        check("rst_release gnt", 32'(gnt), 32'h0);

        foreach (vecs[i]) begin
            req  = vecs[i].req;
            din0 = vecs[i].d0; din1 = vecs[i].d1; din2 = vecs[i].d2; din3 = vecs[i].d3;
            step();
            check($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("row%0d sel", i), 32'(sel), 32'(vecs[i].sel));
            check($sformatf("row%0d dout", i), 32'(dout), 32'(vecs[i].dout));
            check($sformatf("row%0d vld", i), 32'(dout_vld), 32'(vecs[i].vld));
        end

        // Async reset in the middle of a burst to requester 0.
        req  = 4'h1;
        din0 = 8'h77;
        step();
        check("burst beat1 dout", 32'(dout), 32'h77);
        check("burst beat1 vld", 32'(dout_vld), 32'h1);
        step();
        check("burst beat2 gnt", 32'(gnt), 32'h1);
        check("burst beat2 vld", 32'(dout_vld), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst gnt", 32'(gnt), 32'h0);
        check("midrst vld", 32'(dout_vld), 32'h0);
        check("midrst dout", 32'(dout), 32'h0);
        check("midrst sel", 32'(sel), 32'h0);
        step();
        check("midrst no_beat3 vld", 32'(dout_vld), 32'h0);
        check("midrst no_beat3 gnt", 32'(gnt), 32'h0);
        rst = 1'b0;
        req = 4'hF;
        step();
        check("post_rst gnt", 32'(gnt), 32'h1);
        check("post_rst sel", 32'(sel), 32'h0);
        check("post_rst vld", 32'(dout_vld), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
